// File: rtl/uart_boot_loader.sv
// UART 8N1 receiver feeding a little-endian word assembler that streams a
// program image into MCU memory; loading_active holds the MCU in reset meanwhile.
module uart_boot_loader #(
  parameter int CLK_FREQUENCY = 50000000,
  parameter int BAUD_RATE     = 115200,
  parameter int ADDR_WIDTH    = 12,
  parameter int IDLE_TIMEOUT  = 5000000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx,
  output logic                  loading_active,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  byte_valid,
  output logic [7:0]            byte_data,
  output logic                  frame_error
);

  localparam int DIV = CLK_FREQUENCY / BAUD_RATE;
  localparam int CW  = $clog2(DIV + 1);
  localparam int TW  = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(IDLE_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      bit_idx, bit_idx_n;
  logic [7:0]      shift, shift_n;
  logic            byte_ok, frm_err;
  logic            rx_meta, rx_s, rx_prev;

  logic [1:0]            byte_cnt;
  logic [23:0]           word_buf;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [TW-1:0]         to_cnt;

  // Synchronizer and edge-history flops idle high so reset never fakes a start bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = (cnt != '0) ? cnt - CW'(1) : cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    byte_ok   = 1'b0;
    frm_err   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = cnt;
        if (rx_prev && !rx_s) begin
          cnt_n   = HALF_LOAD;
          state_n = START;
        end
      end
      START: begin
        if (cnt == '0) begin
          if (!rx_s) begin
            cnt_n     = FULL_LOAD;
            bit_idx_n = 3'd0;
            state_n   = DATA;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt == '0) begin
          shift_n = {rx_s, shift[7:1]};
          cnt_n   = FULL_LOAD;
          if (bit_idx == 3'd7) state_n = STOP;
          else bit_idx_n = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (cnt == '0) begin
          byte_ok = rx_s;
          frm_err = !rx_s;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A byte arriving in the same cycle as the timeout keeps the session alive
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_valid     <= 1'b0;
      byte_data      <= '0;
      frame_error    <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      loading_active <= 1'b0;
      byte_cnt       <= '0;
      word_buf       <= '0;
      word_addr      <= '0;
      to_cnt         <= '0;
    end else begin
      byte_valid  <= byte_ok;
      frame_error <= frm_err;
      mem_we      <= 1'b0;
      if (byte_ok) begin
        byte_data      <= shift;
        loading_active <= 1'b1;
        to_cnt         <= '0;
        unique case (byte_cnt)
          2'd0: word_buf[7:0]   <= shift;
          2'd1: word_buf[15:8]  <= shift;
          2'd2: word_buf[23:16] <= shift;
          default: begin
            mem_we    <= 1'b1;
            mem_wdata <= {shift, word_buf};
            mem_addr  <= word_addr;
            word_addr <= word_addr + ADDR_WIDTH'(1);
          end
        endcase
        byte_cnt <= byte_cnt + 2'd1;
      end else if (loading_active) begin
        if (to_cnt == TO_LAST) begin
          loading_active <= 1'b0;
          to_cnt         <= '0;
          byte_cnt       <= '0;
          word_addr      <= '0;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: two instances (12-bit and 2-bit
// address) share one rx line; a monitor checks every strobe against queues.
module tb_uart_boot_loader;

  localparam int DIV = 16;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rx = 1'b1;

  logic        la_a, we_a, bv_a, fe_a, la_b, we_b, bv_b, fe_b;
  logic [7:0]  bd_a, bd_b;
  logic [31:0] wd_a, wd_b;
  logic [11:0] addr_a;
  logic [1:0]  addr_b;

  logic        la[2], we[2], bv[2], fe[2];
  logic [7:0]  bd[2];
  logic [31:0] wd[2];
  logic [11:0] ma[2];

  logic [7:0] byte_q[$];
  wr_t        wr_q[$];
  int         fe_exp = 0;
  int         rd_byte[2] = '{0, 0};
  int         rd_wr[2]   = '{0, 0};
  int         fe_seen[2] = '{0, 0};
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  uart_boot_loader #(.CLK_FREQUENCY(1600000), .BAUD_RATE(100000),
                     .ADDR_WIDTH(12), .IDLE_TIMEOUT(2000)) dut_a (
    .clk(clk), .reset_n(reset_n), .rx(rx), .loading_active(la_a),
    .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wd_a), .byte_valid(bv_a),
    .byte_data(bd_a), .frame_error(fe_a));

  uart_boot_loader #(.CLK_FREQUENCY(1600000), .BAUD_RATE(100000),
                     .ADDR_WIDTH(2), .IDLE_TIMEOUT(2000)) dut_b (
    .clk(clk), .reset_n(reset_n), .rx(rx), .loading_active(la_b),
    .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wd_b), .byte_valid(bv_b),
    .byte_data(bd_b), .frame_error(fe_b));

  assign la[0] = la_a;  assign la[1] = la_b;
  assign we[0] = we_a;  assign we[1] = we_b;
  assign bv[0] = bv_a;  assign bv[1] = bv_b;
  assign fe[0] = fe_a;  assign fe[1] = fe_b;
  assign bd[0] = bd_a;  assign bd[1] = bd_b;
  assign wd[0] = wd_a;  assign wd[1] = wd_b;
  assign ma[0] = addr_a;
  assign ma[1] = {10'b0, addr_b};

  // Monitor: every strobe must match the oldest unconsumed expectation
  always @(negedge clk) begin
    if (reset_n) begin
      for (int d = 0; d < 2; d++) begin
        if (bv[d]) begin
          checks++;
          if (rd_byte[d] >= byte_q.size()) begin
            errors++;
            $display("[TB] FAIL byte_valid dut%0d: got strobe with byte_data=%h, required no strobe", d, bd[d]);
          end else begin
            if (bd[d] !== byte_q[rd_byte[d]]) begin
              errors++;
              $display("[TB] FAIL byte_data dut%0d: got %h, required %h", d, bd[d], byte_q[rd_byte[d]]);
            end
            rd_byte[d]++;
          end
        end
        if (we[d]) begin
          checks++;
          if (rd_wr[d] >= wr_q.size()) begin
            errors++;
            $display("[TB] FAIL mem_we dut%0d: got write addr=%h data=%h, required no write", d, ma[d], wd[d]);
          end else begin
            logic [11:0] ea;
            ea = (d == 0) ? wr_q[rd_wr[d]].addr : {10'b0, wr_q[rd_wr[d]].addr[1:0]};
            if (ma[d] !== ea || wd[d] !== wr_q[rd_wr[d]].data) begin
              errors++;
              $display("[TB] FAIL mem_write dut%0d: got addr=%h data=%h, required addr=%h data=%h",
                       d, ma[d], wd[d], ea, wr_q[rd_wr[d]].data);
            end
            rd_wr[d]++;
          end
        end
        if (fe[d]) begin
          checks++;
          if (fe_seen[d] >= fe_exp) begin
            errors++;
            $display("[TB] FAIL frame_error dut%0d: got strobe #%0d, required %0d strobes", d, fe_seen[d] + 1, fe_exp);
          end
          fe_seen[d]++;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic expectWrite(input logic [11:0] addr, input logic [31:0] data);
    wr_t w;
    w.addr = addr;
    w.data = data;
    wr_q.push_back(w);
  endtask

  // One 8N1 frame; a low stop bit is followed by idle so the line is seen high
  task automatic applyStimulus(input logic [7:0] b, input logic good_stop);
    if (good_stop) byte_q.push_back(b);
    else fe_exp++;
    @(negedge clk) rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = good_stop;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic idleTimeout();
    repeat (2100) @(negedge clk);
  endtask

  task automatic checkActive(input logic exp, input string name);
    checkOutput({name, "_dut0"}, {31'b0, la[0]}, {31'b0, exp});
    checkOutput({name, "_dut1"}, {31'b0, la[1]}, {31'b0, exp});
  endtask

  initial begin
    logic [7:0] img[20];
    logic [7:0] pre[5];
    int wait_cnt;

    repeat (5) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("reset_loading_active_dut%0d", d), {31'b0, la[d]}, 32'd0);
      checkOutput($sformatf("reset_mem_we_dut%0d", d), {31'b0, we[d]}, 32'd0);
      checkOutput($sformatf("reset_mem_addr_dut%0d", d), {20'b0, ma[d]}, 32'd0);
      checkOutput($sformatf("reset_mem_wdata_dut%0d", d), wd[d], 32'd0);
      checkOutput($sformatf("reset_byte_data_dut%0d", d), {24'b0, bd[d]}, 32'd0);
      checkOutput($sformatf("reset_byte_valid_dut%0d", d), {31'b0, bv[d]}, 32'd0);
      checkOutput($sformatf("reset_frame_error_dut%0d", d), {31'b0, fe[d]}, 32'd0);
    end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] single byte starts a session");
    applyStimulus(8'h55, 1'b1);
    checkActive(1'b1, "active_after_first_byte");
    idleTimeout();
    checkActive(1'b0, "active_after_partial_timeout");

    $display("[TB] two words");
    expectWrite(12'd0, 32'h00000513);
    expectWrite(12'd1, 32'h00100093);
    applyStimulus(8'h13, 1'b1); applyStimulus(8'h05, 1'b1);
    applyStimulus(8'h00, 1'b1); applyStimulus(8'h00, 1'b1);
    applyStimulus(8'h93, 1'b1); applyStimulus(8'h00, 1'b1);
    applyStimulus(8'h10, 1'b1); applyStimulus(8'h00, 1'b1);
    idleTimeout();

    $display("[TB] frame error and glitch");
    expectWrite(12'd0, 32'h04030201);
    applyStimulus(8'hA5, 1'b0);
    checkActive(1'b0, "active_after_frame_error");
    applyStimulus(8'h01, 1'b1); applyStimulus(8'h02, 1'b1);
    @(negedge clk) rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    applyStimulus(8'h03, 1'b1); applyStimulus(8'h04, 1'b1);
    checkActive(1'b1, "active_after_glitch_session");
    idleTimeout();

    $display("[TB] timeout discards partial word");
    applyStimulus(8'hAA, 1'b1); applyStimulus(8'hBB, 1'b1);
    repeat (1900) @(negedge clk);
    checkActive(1'b1, "active_before_timeout");
    repeat (200) @(negedge clk);
    checkActive(1'b0, "active_after_timeout");
    expectWrite(12'd0, 32'hDEADBEEF);
    applyStimulus(8'hEF, 1'b1); applyStimulus(8'hBE, 1'b1);
    applyStimulus(8'hAD, 1'b1); applyStimulus(8'hDE, 1'b1);
    idleTimeout();

    $display("[TB] address wrap");
    for (int i = 0; i < 20; i++) img[i] = 8'(8'h20 + 8'(i * 7));
    for (int k = 0; k < 5; k++)
      expectWrite(12'(k), {img[4*k+3], img[4*k+2], img[4*k+1], img[4*k]});
    for (int i = 0; i < 20; i++) applyStimulus(img[i], 1'b1);

    $display("[TB] reset mid-frame");
    pre[0] = 8'h00;
    @(negedge clk) rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      rx = ~rx;
      repeat (DIV) @(negedge clk);
    end
    #3 reset_n = 1'b0;
    #1;
    checkOutput("midreset_loading_active", {31'b0, la[0]}, 32'd0);
    checkOutput("midreset_byte_data", {24'b0, bd[0]}, {24'b0, pre[0]});
    checkOutput("midreset_mem_wdata", wd[0], 32'd0);
    checkOutput("midreset_mem_addr_dut1", {20'b0, ma[1]}, 32'd0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    applyStimulus(8'h3C, 1'b1);
    checkActive(1'b1, "active_after_reset_byte");

    wait_cnt = 0;
    while ((rd_byte[0] < byte_q.size() || rd_byte[1] < byte_q.size() ||
            rd_wr[0] < wr_q.size() || rd_wr[1] < wr_q.size()) && wait_cnt < 500) begin
      @(negedge clk);
      wait_cnt++;
    end
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("bytes_seen_dut%0d", d), rd_byte[d], byte_q.size());
      checkOutput($sformatf("writes_seen_dut%0d", d), rd_wr[d], wr_q.size());
      checkOutput($sformatf("frame_errors_seen_dut%0d", d), fe_seen[d], fe_exp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
